rnd_mem_checker: RTL and testbench

- Sequencer/checker that sits directly downstream of the pseudo-random vector generator in the SDRAM memtest.
- Drives the generator's init/save/restore/next strobes and consumes its output vector.
- Per pass: writes the generator sequence to an address range through a req/ack memory port, rewinds the generator, reads the range back and compares each word.
- Counts passes and mismatches for the OSD/LED status logic.

---
 rtl/rnd_mem_checker.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_rnd_mem_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnd_mem_checker.sv
// rnd_mem_checker
//   Sequencer/checker placed directly after the pseudo-random vector
//   generator of the SDRAM memtest. Each pass it initialises or continues
//   the generator sequence, writes it to words 0 .. 2**ADDR_W-1 through a
//   req/ack memory port, rewinds the generator, then reads the range back
//   and compares every word. Pass and mismatch counters feed the OSD/LED
//   status logic.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        level: 1 = keep running passes, 0 = stop after current pass
//   rnd_vec      generator output (current generator state)
//   rnd_init     generator init strobe (held INIT_CYC cycles)
//   rnd_save     generator save strobe (1 cycle)
//   rnd_restore  generator restore strobe (1 cycle)
//   rnd_next     generator step strobe (1 cycle)
//   mem_req      memory request, held until mem_ack
//   mem_we       1 = write, 0 = read (valid while mem_req)
//   mem_addr     word address (valid while mem_req)
//   mem_wdata    write data (valid while mem_req && mem_we)
//   mem_ack      one-cycle completion; read data valid in the ack cycle
//   mem_rdata    read data
//   busy         high in every state except IDLE
//   pass_done    one-cycle pulse at the end of each pass
//   pass_cnt     completed passes (wraps)
//   err_cnt      mismatching words since start (saturates)
//   err_flag     sticky mismatch flag
//
// Every output is driven straight from a register. The combinational block
// computes the next state together with the next value of every output.

module rnd_mem_checker #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int ERR_W    = 16,
  parameter int PASS_W   = 16,
  parameter int INIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] rnd_vec,
  output logic              rnd_init,
  output logic              rnd_save,
  output logic              rnd_restore,
  output logic              rnd_next,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              pass_done,
  output logic [PASS_W-1:0] pass_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              err_flag
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    INIT     = 4'd1,
    SAVE     = 4'd2,
    WR_REQ   = 4'd3,
    WR_STEP  = 4'd4,
    RESTORE  = 4'd5,
    RD_WAIT0 = 4'd6,
    RD_REQ   = 4'd7,
    RD_STEP  = 4'd8,
    PASS_END = 4'd9
  } state_t;

  // INIT counts INIT_CYC strobe cycles plus one settle cycle.
  localparam int CNT_W = (INIT_CYC < 1) ? 1 : $clog2(INIT_CYC + 1);
  localparam logic [CNT_W-1:0] INIT_HOLD_LAST = CNT_W'(INIT_CYC - 1);
  localparam logic [CNT_W-1:0] INIT_SETTLE    = CNT_W'(INIT_CYC);
  localparam logic [ADDR_W-1:0] ADDR_LAST     = {ADDR_W{1'b1}};

  // Saturating increment for the error counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (v == {ERR_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + ERR_W'(1'b1);
    end
    return r;
  endfunction

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              init_r, init_s;
  logic              save_r, save_s;
  logic              restore_r, restore_s;
  logic              next_r, next_s;
  logic              req_r, req_s;
  logic              we_r, we_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              done_r, done_s;
  logic [PASS_W-1:0] pass_r, pass_s;
  logic [ERR_W-1:0]  err_r, err_s;
  logic              flag_r, flag_s;
  logic              busy_r, busy_s;

  // Next-state and next-output logic of the pass sequencer.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    init_s    = 1'b0;
    save_s    = 1'b0;
    restore_s = 1'b0;
    next_s    = 1'b0;
    req_s     = req_r;
    we_s      = we_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    done_s    = 1'b0;
    pass_s    = pass_r;
    err_s     = err_r;
    flag_s    = flag_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = INIT;
          cnt_s   = {CNT_W{1'b0}};
          init_s  = 1'b1;
          pass_s  = {PASS_W{1'b0}};
          err_s   = {ERR_W{1'b0}};
          flag_s  = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end

      INIT: begin
        if (cnt_r == INIT_SETTLE) begin
          state_s = SAVE;
          save_s  = 1'b1;
          addr_s  = {ADDR_W{1'b0}};
        end else begin
          cnt_s  = cnt_r + CNT_W'(1'b1);
          init_s = (cnt_r < INIT_HOLD_LAST);
        end
      end

      SAVE: begin
        state_s = WR_REQ;
      end

      // The generator steps on the same edge that enters WR_REQ, so the
      // write word is captured in the first WR_REQ cycle and the request
      // is raised together with it.
      WR_REQ: begin
        if (!req_r) begin
          req_s   = 1'b1;
          we_s    = 1'b1;
          wdata_s = rnd_vec;
        end else if (mem_ack) begin
          req_s   = 1'b0;
          we_s    = 1'b0;
          next_s  = 1'b1;
          state_s = WR_STEP;
        end else begin
          state_s = WR_REQ;
        end
      end

      WR_STEP: begin
        if (addr_r == ADDR_LAST) begin
          state_s   = RESTORE;
          restore_s = 1'b1;
          addr_s    = {ADDR_W{1'b0}};
        end else begin
          state_s = WR_REQ;
          addr_s  = addr_r + ADDR_W'(1'b1);
        end
      end

      RESTORE: begin
        state_s = RD_WAIT0;
      end

      RD_WAIT0: begin
        state_s = RD_REQ;
        req_s   = 1'b1;
        we_s    = 1'b0;
      end

      RD_REQ: begin
        if (req_r && mem_ack) begin
          req_s   = 1'b0;
          next_s  = 1'b1;
          state_s = RD_STEP;
          if (mem_rdata != rnd_vec) begin
            err_s  = sat_inc(err_r);
            flag_s = 1'b1;
          end else begin
            err_s = err_r;
          end
        end else begin
          state_s = RD_REQ;
        end
      end

      RD_STEP: begin
        if (addr_r == ADDR_LAST) begin
          state_s = PASS_END;
          done_s  = 1'b1;
          pass_s  = pass_r + PASS_W'(1'b1);
        end else begin
          state_s = RD_REQ;
          addr_s  = addr_r + ADDR_W'(1'b1);
          req_s   = 1'b1;
          we_s    = 1'b0;
        end
      end

      // Continuing passes skip INIT so the sequence carries on.
      PASS_END: begin
        if (start) begin
          state_s = SAVE;
          save_s  = 1'b1;
          addr_s  = {ADDR_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end

      default: begin
        state_s = IDLE;
        req_s   = 1'b0;
        we_s    = 1'b0;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      init_r    <= 1'b0;
      save_r    <= 1'b0;
      restore_r <= 1'b0;
      next_r    <= 1'b0;
      req_r     <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      done_r    <= 1'b0;
      pass_r    <= {PASS_W{1'b0}};
      err_r     <= {ERR_W{1'b0}};
      flag_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      init_r    <= init_s;
      save_r    <= save_s;
      restore_r <= restore_s;
      next_r    <= next_s;
      req_r     <= req_s;
      we_r      <= we_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      done_r    <= done_s;
      pass_r    <= pass_s;
      err_r     <= err_s;
      flag_r    <= flag_s;
      busy_r    <= busy_s;
    end
  end

  assign rnd_init    = init_r;
  assign rnd_save    = save_r;
  assign rnd_restore = restore_r;
  assign rnd_next    = next_r;
  assign mem_req     = req_r;
  assign mem_we      = we_r;
  assign mem_addr    = addr_r;
  assign mem_wdata   = wdata_r;
  assign busy        = busy_r;
  assign pass_done   = done_r;
  assign pass_cnt    = pass_r;
  assign err_cnt     = err_r;
  assign err_flag    = flag_r;

endmodule

// File: tb/tb_rnd_mem_checker.sv
// Testbench for rnd_mem_checker: 4-word address range, 2-bit error counter.
// Includes a generator model (add 36653, rotate right 1) and a req/ack
// memory model with configurable ack delay and read corruption.

module tb_rnd_mem_checker;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int EW = 2;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] rnd_vec;
  logic          rnd_init, rnd_save, rnd_restore, rnd_next;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          busy, pass_done;
  logic [PW-1:0] pass_cnt;
  logic [EW-1:0] err_cnt;
  logic          err_flag;

  rnd_mem_checker #(
    .DATA_W(DW), .ADDR_W(AW), .ERR_W(EW), .PASS_W(PW), .INIT_CYC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rnd_vec(rnd_vec),
    .rnd_init(rnd_init), .rnd_save(rnd_save), .rnd_restore(rnd_restore),
    .rnd_next(rnd_next), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .pass_done(pass_done),
    .pass_cnt(pass_cnt), .err_cnt(err_cnt), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_ok  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_ok++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] gstep(input logic [15:0] v);
    logic [15:0] s;
    s = v + 16'd36653;
    return {s[0], s[15:1]};
  endfunction

  // Generator model.
  logic [15:0] g_r, gs_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_r  <= 16'd0;
      gs_r <= 16'd0;
    end else begin
      if (rnd_init)         g_r <= 16'd0;
      else if (rnd_restore) g_r <= gs_r;
      else if (rnd_next)    g_r <= gstep(g_r);
      if (rnd_save) gs_r <= g_r;
    end
  end
  assign rnd_vec = g_r;

  // Memory model: ack after ack_delay extra cycles; rd_mode 1 flips bit 0
  // of word 2 on read, rd_mode 2 returns zero on every read.
  logic [15:0] mem_arr [0:3];
  int ack_delay = 0;
  int rd_mode   = 0;
  int dly_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack   <= 1'b0;
      mem_rdata <= 16'd0;
      dly_cnt   <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_req && !mem_ack) begin
        if (dly_cnt >= ack_delay) begin
          mem_ack <= 1'b1;
          dly_cnt <= 0;
          if (mem_we) mem_arr[mem_addr] <= mem_wdata;
          else if (rd_mode == 2) mem_rdata <= 16'd0;
          else if (rd_mode == 1 && mem_addr == 2'd2) mem_rdata <= mem_arr[mem_addr] ^ 16'h0001;
          else mem_rdata <= mem_arr[mem_addr];
        end else begin
          dly_cnt <= dly_cnt + 1;
        end
      end
    end
  end

  // Monitor: write scoreboard, access counts, request stability, strobe overlap.
  logic [15:0] exp_w = 16'd0;
  int wr_idx = 0, wr_cnt = 0, rd_cnt = 0, unstable_cnt = 0, multi_cnt = 0;
  logic        hold_v = 1'b0;
  logic [18:0] hold_val;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if ($countones({rnd_init, rnd_save, rnd_restore, rnd_next}) > 1) multi_cnt++;
      if (mem_req && hold_v && ({mem_we, mem_addr, mem_wdata} !== hold_val)) unstable_cnt++;
      hold_v   = mem_req && !mem_ack;
      hold_val = {mem_we, mem_addr, mem_wdata};
      if (rnd_init) begin
        exp_w  = 16'd0;
        wr_idx = 0;
      end
      if (mem_req && mem_ack && mem_we) begin
        check("wr_data", 64'(mem_wdata), 64'(exp_w));
        check("wr_addr", 64'(mem_addr), 64'(wr_idx % 4));
        exp_w = gstep(exp_w);
        wr_idx++;
        wr_cnt++;
      end
      if (mem_req && mem_ack && !mem_we) rd_cnt++;
    end
  end

  typedef struct {
    int          mode;
    int          dly;
    int          passes;
    logic [1:0]  exp_err;
    logic        exp_flag;
    logic [15:0] exp_pass;
  } vec_t;

  vec_t tv [6];

  // First four generator words: 0x0000, 0xC796, 0xAB61, then
  // 0xAB61+0x8F2D = 0x3A8E (mod 2^16), rotated right -> 0x1D47.
  logic [15:0] first_words [0:3];

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_counts();
    wr_cnt = 0; rd_cnt = 0; unstable_cnt = 0; multi_cnt = 0;
  endtask

  task automatic wait_pass(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (pass_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({rnd_init, rnd_save, rnd_restore, rnd_next, mem_req, mem_we,
                mem_addr, mem_wdata, busy, pass_done, pass_cnt, err_cnt, err_flag});
  endfunction

  initial begin
    bit ok;
    int n;

    tv[0] = '{mode: 0, dly: 0, passes: 1, exp_err: 2'd0, exp_flag: 1'b0, exp_pass: 16'd1};
    tv[1] = '{mode: 1, dly: 0, passes: 1, exp_err: 2'd1, exp_flag: 1'b1, exp_pass: 16'd1};
    tv[2] = '{mode: 1, dly: 0, passes: 2, exp_err: 2'd2, exp_flag: 1'b1, exp_pass: 16'd2};
    tv[3] = '{mode: 0, dly: 5, passes: 1, exp_err: 2'd0, exp_flag: 1'b0, exp_pass: 16'd1};
    tv[4] = '{mode: 2, dly: 0, passes: 1, exp_err: 2'd3, exp_flag: 1'b1, exp_pass: 16'd1};
    tv[5] = '{mode: 2, dly: 0, passes: 2, exp_err: 2'd3, exp_flag: 1'b1, exp_pass: 16'd2};
    first_words[0] = 16'h0000;
    first_words[1] = 16'hC796;
    first_words[2] = 16'hAB61;
    first_words[3] = 16'h1D47;

    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_outputs", all_outs(), 64'd0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      rd_mode   = tv[i].mode;
      ack_delay = tv[i].dly;
      check("idle_after_reset", all_outs(), 64'd0);
      clear_counts();
      start = 1'b1;
      for (int p = 1; p <= tv[i].passes; p++) begin
        wait_pass(ok);
        if (!ok) check("pass_timeout", 64'd0, 64'd1);
        if (p == tv[i].passes) start = 1'b0;
      end
      @(negedge clk);
      check("pass_done_pulse", 64'(pass_done), 64'd0);
      repeat (2) @(negedge clk);
      check("busy_end", 64'(busy), 64'd0);
      check("pass_cnt", 64'(pass_cnt), 64'(tv[i].exp_pass));
      check("err_cnt", 64'(err_cnt), 64'(tv[i].exp_err));
      check("err_flag", 64'(err_flag), 64'(tv[i].exp_flag));
      check("wr_count", 64'(wr_cnt), 64'(4 * tv[i].passes));
      check("rd_count", 64'(rd_cnt), 64'(4 * tv[i].passes));
      check("req_stable", 64'(unstable_cnt), 64'd0);
      check("one_strobe", 64'(multi_cnt), 64'd0);
      if (i == 0) begin
        for (int a = 0; a < 4; a++) check("mem_word", 64'(mem_arr[a]), 64'(first_words[a]));
      end
    end

    // start dropped during the read phase: pass completes, then IDLE.
    do_reset();
    rd_mode = 0; ack_delay = 0;
    clear_counts();
    start = 1'b1;
    n = 0;
    while (!(mem_req && !mem_we) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("read_phase_seen", 64'(mem_req && !mem_we), 64'd1);
    start = 1'b0;
    wait_pass(ok);
    check("drop_pass_done", 64'(ok), 64'd1);
    check("drop_pass_cnt", 64'(pass_cnt), 64'd1);
    repeat (10) @(negedge clk);
    check("drop_idle", 64'({busy, mem_req}), 64'd0);
    check("drop_wr_count", 64'(wr_cnt), 64'd4);

    // Reset in the middle of a delayed write.
    do_reset();
    rd_mode = 0; ack_delay = 5;
    clear_counts();
    start = 1'b1;
    n = 0;
    while (!(mem_req && mem_we && mem_addr == 2'd1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mid_write_seen", 64'(mem_req && mem_we && mem_addr == 2'd1), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("stay_idle", 64'({busy, mem_req, rnd_init}), 64'd0);
    clear_counts();
    start = 1'b1;
    n = 0;
    while (!rnd_init && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("restart_init", 64'(rnd_init), 64'd1);
    n = 0;
    while (!(mem_req && mem_we && mem_ack) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("restart_addr0", 64'({mem_req, mem_addr, mem_wdata}), 64'({1'b1, 2'd0, 16'h0000}));
    start = 1'b0;
    wait_pass(ok);
    check("restart_pass_done", 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
    check("restart_end", 64'({busy, pass_cnt, err_cnt}), 64'({1'b0, 16'd1, 2'd0}));
    check("restart_wr_count", 64'(wr_cnt), 64'd4);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
